// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler sharing one bank of NBITS JK bits among NREQ requesters; JK_BANK_SR_MODE_EN selects SR storage.
// Latency: the winner's command lands on Q at the same edge that raises its one-cycle gnt pulse.
// Backpressure: losers hold req level; a requester is masked in its own gnt cycle and waits at most NREQ-1 grants.
module jk_bank_scheduler #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    cmd,
    input  logic [IDXW*NREQ-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [NBITS-1:0]     Q,
    output logic [NBITS-1:0]     Q_bar,
    output logic                 err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [NBITS-1:0] q_q, q_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [1:0]       cmd_a [NREQ];
    logic [IDXW-1:0]  idx_a [NREQ];
    logic [NREQ-1:0]  elig;
    logic             win_vld;
    logic [PW-1:0]    win_idx;
    logic [1:0]       win_cmd;
    logic [IDXW-1:0]  win_bit;

    for (genvar r = 0; r < NREQ; r++) begin : g_split
        assign cmd_a[r] = cmd[2*r +: 2];
        assign idx_a[r] = idx[IDXW*r +: IDXW];
    end

    // Masking with the registered grant stops a requester being re-granted while it drops req.
    assign elig = req & ~gnt_q;

    always_comb begin
        logic [PW:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!win_vld && elig[cand[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign win_cmd = cmd_a[win_idx];
    assign win_bit = idx_a[win_idx];

    always_comb begin
        logic [PW:0] nxt;
        nxt   = {1'b0, win_idx} + (PW+1)'(1);
        if (nxt == (PW+1)'(NREQ)) begin
            nxt = '0;
        end
        ptr_d = win_vld ? nxt[PW-1:0] : ptr_q;
        gnt_d = '0;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
        end
        busy_d = |elig;
    end

`ifdef JK_BANK_SR_MODE_EN
    logic err_q, err_d;

    // S=R=1 is illegal storage input: grant it, leave the bit alone, flag it until reset.
    always_comb begin
        q_d   = q_q;
        err_d = err_q;
        if (win_vld) begin
            case (win_cmd)
                2'b01:   q_d[win_bit] = 1'b0;
                2'b10:   q_d[win_bit] = 1'b1;
                2'b11:   err_d        = 1'b1;
                default: q_d          = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    always_comb begin
        q_d = q_q;
        if (win_vld) begin
            case (win_cmd)
                2'b01:   q_d[win_bit] = 1'b0;
                2'b10:   q_d[win_bit] = 1'b1;
                2'b11:   q_d[win_bit] = ~q_q[win_bit];
                default: q_d          = q_q;
            endcase
        end
    end

    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            q_q    <= '0;
            ptr_q  <= '0;
        end else begin
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
            q_q    <= q_d;
            ptr_q  <= ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign Q     = q_q;
    assign Q_bar = ~q_q;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed bench for jk_bank_scheduler: each scenario drives vectors and checks hand-computed values.
module tb_jk_bank_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] cmd;
    logic [11:0] idx;
    logic [3:0] gnt;
    logic       busy;
    logic [7:0] Q;
    logic [7:0] Q_bar;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    jk_bank_scheduler #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt), .busy(busy), .Q(Q), .Q_bar(Q_bar), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int r, input logic [1:0] c, input logic [2:0] b);
        cmd[2*r +: 2] = c;
        idx[3*r +: 3] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cmd = '0;
        idx = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        cmd = '0;
        idx = '0;
        tick();
        tick();
        n_vec++; if (Q !== 8'h00) begin n_bad++; $display("FAIL reset_Q got %h want 00", Q); end
        n_vec++; if (Q_bar !== 8'hFF) begin n_bad++; $display("FAIL reset_Qbar got %h want ff", Q_bar); end
        n_vec++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_first_busy got %b want 1", busy); end
        req = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        set_cmd(2, 2'b10, 3'd5);
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_set_gnt got %b want 0100", gnt); end
        n_vec++; if (Q !== 8'h20) begin n_bad++; $display("FAIL single_set_Q got %h want 20", Q); end
        req = 4'b0000;
        tick();
        n_vec++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_idle_gnt got %b want 0000", gnt); end
        n_vec++; if (Q !== 8'h20) begin n_bad++; $display("FAIL single_hold_Q got %h want 20", Q); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", busy); end
        req = 4'b0100;
        set_cmd(2, 2'b01, 3'd5);
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_clr_gnt got %b want 0100", gnt); end
        n_vec++; if (Q !== 8'h00) begin n_bad++; $display("FAIL single_clr_Q got %h want 00", Q); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        logic [7:0] exp_q [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
        exp_q[0] = 8'h01;   exp_q[1] = 8'h03;   exp_q[2] = 8'h07;   exp_q[3] = 8'h0F;
        do_reset();
        for (int r = 0; r < 4; r++) set_cmd(r, 2'b10, 3'(r));
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (gnt !== exp_g[k]) begin
                n_bad++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_g[k]);
            end
            n_vec++;
            if (Q !== exp_q[k]) begin
                n_bad++; $display("FAIL rr_Q[%0d] got %h want %h", k, Q, exp_q[k]);
            end
        end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy got %b want 1", busy); end
        req = 4'b0000;
        tick();
        n_vec++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_end_gnt got %b want 0000", gnt); end
        n_vec++; if (Q !== 8'h0F) begin n_bad++; $display("FAIL rr_end_Q got %h want 0f", Q); end
    endtask

    task automatic test_same_bit();
        logic [7:0] q2;
`ifdef JK_BANK_SR_MODE_EN
        q2 = 8'h00;
`else
        q2 = 8'h00;
`endif
        do_reset();
        set_cmd(1, 2'b11, 3'd0);
        set_cmd(3, 2'b11, 3'd0);
        req = 4'b1010;
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL same_first_gnt got %b want 0010", gnt); end
`ifdef JK_BANK_SR_MODE_EN
        n_vec++; if (Q !== 8'h00) begin n_bad++; $display("FAIL same_first_Q got %h want 00", Q); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL same_first_err got %b want 1", err); end
`else
        n_vec++; if (Q !== 8'h01) begin n_bad++; $display("FAIL same_first_Q got %h want 01", Q); end
`endif
        req = 4'b1000;
        tick();
        n_vec++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL same_second_gnt got %b want 1000", gnt); end
        n_vec++; if (Q !== q2) begin n_bad++; $display("FAIL same_second_Q got %h want %h", Q, q2); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_pre_gnt got %b want 0010", gnt); end
        req = 4'b0000;
        tick();
        req = 4'b0001;
        set_cmd(0, 2'b10, 3'd4);
        rst = 1'b1;
        tick();
        n_vec++; if (Q !== 8'h00) begin n_bad++; $display("FAIL mid_rst_Q got %h want 00", Q); end
        n_vec++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_gnt got %b want 0000", gnt); end
        rst = 1'b0;
        req = 4'b1001;
        set_cmd(3, 2'b00, 3'd7);
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL mid_ptr_gnt got %b want 0001", gnt); end
        n_vec++; if (Q !== 8'h10) begin n_bad++; $display("FAIL mid_ptr_Q got %h want 10", Q); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_cmd11();
        do_reset();
        req = 4'b0001;
        set_cmd(0, 2'b10, 3'd3);
        tick();
        n_vec++; if (Q !== 8'h08) begin n_bad++; $display("FAIL c11_pre_Q got %h want 08", Q); end
        req = 4'b0000;
        tick();
        req = 4'b0001;
        set_cmd(0, 2'b11, 3'd3);
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL c11_gnt got %b want 0001", gnt); end
        req = 4'b0000;
        tick();
`ifdef JK_BANK_SR_MODE_EN
        n_vec++; if (Q !== 8'h08) begin n_bad++; $display("FAIL c11_Q got %h want 08", Q); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL c11_err_sticky got %b want 1", err); end
`else
        n_vec++; if (Q !== 8'h00) begin n_bad++; $display("FAIL c11_Q got %h want 00", Q); end
        n_vec++; if (Q_bar !== 8'hFF) begin n_bad++; $display("FAIL c11_Qbar got %h want ff", Q_bar); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL c11_err got %b want 0", err); end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL c11_err_rst got %b want 0", err); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        cmd = '0;
        idx = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_same_bit();
        test_reset_mid();
        test_cmd11();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
